// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage MIPS datapath: carries decoded fields,
// operands and control into EX. Also inserts load-use bubbles, handles flush and a sticky halt.
module id_ex_reg (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        flush,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_funct,
    input  logic [15:0] id_imm,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rdat1,
    input  logic [31:0] id_rdat2,
    input  logic [31:0] id_npc,
    input  logic        id_WEN,
    input  logic [1:0]  id_reg_dest,
    input  logic [3:0]  id_alu_op,
    input  logic [1:0]  id_alu_src,
    input  logic        id_mem_ren,
    input  logic        id_mem_wen,
    input  logic [1:0]  id_mem_to_reg,
    input  logic        id_halt,
    output logic [5:0]  ex_opcode,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic [5:0]  ex_funct,
    output logic [15:0] ex_imm,
    output logic [31:0] ex_rdat1,
    output logic [31:0] ex_rdat2,
    output logic [31:0] ex_npc,
    output logic        ex_WEN,
    output logic [1:0]  ex_reg_dest,
    output logic [3:0]  ex_alu_op,
    output logic [1:0]  ex_alu_src,
    output logic        ex_mem_ren,
    output logic        ex_mem_wen,
    output logic [1:0]  ex_mem_to_reg,
    output logic        ex_halt,
    output logic        ex_valid,
    output logic        ld_use_stall,
    output logic        halted,
    output logic [15:0] bubble_cnt
);

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] npc;
        logic        wen;
        logic [1:0]  reg_dest;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_to_reg;
        logic        halt;
    } stage_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    stage_t id_stage;
    stage_t ex_q;
    logic   hazard;

    assign id_stage = '{
        opcode:     id_opcode,
        rs:         id_rs,
        rt:         id_rt,
        rd:         id_rd,
        shamt:      id_shamt,
        funct:      id_funct,
        imm:        id_imm,
        rdat1:      id_rdat1,
        rdat2:      id_rdat2,
        npc:        id_npc,
        wen:        id_WEN,
        reg_dest:   id_reg_dest,
        alu_op:     id_alu_op,
        alu_src:    id_alu_src,
        mem_ren:    id_mem_ren,
        mem_wen:    id_mem_wen,
        mem_to_reg: id_mem_to_reg,
        halt:       id_halt
    };

    // A load in EX whose destination is a source of the instruction sitting in ID.
    assign hazard = ex_valid && ex_q.mem_ren && ex_q.wen && (ex_q.rt != 5'd0) &&
                    ((ex_q.rt == id_rs) || ((ex_q.rt == id_rt) && id_uses_rt));

    // Deliberately not gated by enable so the upstream freeze survives a cache wait.
    assign ld_use_stall = hazard && !flush && !halted;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q       <= '0;
            ex_valid   <= 1'b0;
            halted     <= 1'b0;
            bubble_cnt <= '0;
        end else if (!halted && enable) begin
            if (flush) begin
                ex_q     <= '0;
                ex_valid <= 1'b0;
            end else if (hazard) begin
                ex_q     <= '0;
                ex_valid <= 1'b0;
                if (bubble_cnt != CNT_MAX) begin
                    bubble_cnt <= bubble_cnt + 16'd1;
                end
            end else begin
                ex_q     <= id_stage;
                ex_valid <= 1'b1;
                if (id_halt) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    assign ex_opcode     = ex_q.opcode;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_shamt      = ex_q.shamt;
    assign ex_funct      = ex_q.funct;
    assign ex_imm        = ex_q.imm;
    assign ex_rdat1      = ex_q.rdat1;
    assign ex_rdat2      = ex_q.rdat2;
    assign ex_npc        = ex_q.npc;
    assign ex_WEN        = ex_q.wen;
    assign ex_reg_dest   = ex_q.reg_dest;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_ren    = ex_q.mem_ren;
    assign ex_mem_wen    = ex_q.mem_wen;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_halt       = ex_q.halt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a directed vector table for load, hold, hazard
// and flush behaviour, plus hand-written halt, mid-run reset and saturation sequences.
module tb_id_ex_reg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic        CLK, RST, enable, flush;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm;
    logic        id_uses_rt;
    logic [31:0] id_rdat1, id_rdat2, id_npc;
    logic        id_WEN, id_mem_ren, id_mem_wen, id_halt;
    logic [1:0]  id_reg_dest, id_alu_src, id_mem_to_reg;
    logic [3:0]  id_alu_op;

    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [15:0] ex_imm;
    logic [31:0] ex_rdat1, ex_rdat2, ex_npc;
    logic        ex_WEN, ex_mem_ren, ex_mem_wen, ex_halt, ex_valid;
    logic [1:0]  ex_reg_dest, ex_alu_src, ex_mem_to_reg;
    logic [3:0]  ex_alu_op;
    logic        ld_use_stall, halted;
    logic [15:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_reg dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm), .id_uses_rt(id_uses_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_npc(id_npc),
        .id_WEN(id_WEN), .id_reg_dest(id_reg_dest), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen),
        .id_mem_to_reg(id_mem_to_reg), .id_halt(id_halt),
        .ex_opcode(ex_opcode), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_imm(ex_imm),
        .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_npc(ex_npc),
        .ex_WEN(ex_WEN), .ex_reg_dest(ex_reg_dest), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_halt(ex_halt), .ex_valid(ex_valid),
        .ld_use_stall(ld_use_stall), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        en, fl;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        ur;
        logic [31:0] r1, r2;
        logic        wen, mr;
        logic        x_stall, x_valid;
        logic [5:0]  x_op;
        logic [4:0]  x_rs, x_rt, x_rd;
        logic [31:0] x_r1, x_r2;
        logic        x_wen, x_mr;
        logic [15:0] x_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic ur, input logic [31:0] r1, input logic [31:0] r2,
                         input logic wen, input logic mr, input logic hlt);
        enable        = en;
        flush         = fl;
        id_opcode     = op;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
        id_shamt      = 5'd0;
        id_funct      = (op == OP_ADD) ? 6'h20 : 6'h00;
        id_imm        = {11'd0, rd};
        id_uses_rt    = ur;
        id_rdat1      = r1;
        id_rdat2      = r2;
        id_npc        = r1 + 32'd4;
        id_WEN        = wen;
        id_reg_dest   = wen ? 2'd1 : 2'd0;
        id_alu_op     = 4'd2;
        id_alu_src    = (op == OP_ADD) ? 2'd0 : 2'd1;
        id_mem_ren    = mr;
        id_mem_wen    = (op == OP_SW);
        id_mem_to_reg = mr ? 2'd1 : 2'd0;
        id_halt       = hlt;
    endtask

    function automatic vec_t v(
        input logic en, input logic fl, input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic ur, input logic [31:0] r1,
        input logic [31:0] r2, input logic wen, input logic mr,
        input logic xs, input logic xv, input logic [5:0] xop, input logic [4:0] xrs,
        input logic [4:0] xrt, input logic [4:0] xrd, input logic [31:0] xr1,
        input logic [31:0] xr2, input logic xwen, input logic xmr, input logic [15:0] xcnt);
        vec_t r;
        r = '{en, fl, op, rs, rt, rd, ur, r1, r2, wen, mr,
              xs, xv, xop, xrs, xrt, xrd, xr1, xr2, xwen, xmr, xcnt};
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ex_valid), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_cnt"}, 32'(bubble_cnt), 32'd0);
        check({tag, "_stall"}, 32'(ld_use_stall), 32'd0);
        check({tag, "_fields"},
              32'(|{ex_opcode, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_imm, ex_rdat1,
                    ex_rdat2, ex_npc, ex_WEN, ex_reg_dest, ex_alu_op, ex_alu_src,
                    ex_mem_ren, ex_mem_wen, ex_mem_to_reg, ex_halt}), 32'd0);
    endtask

    initial begin
        // en fl op rs rt rd ur rdat1 rdat2 wen mr | stall valid op rs rt rd rdat1 rdat2 wen mr cnt
        vecs.push_back(v(1,0,OP_ADD, 2, 3, 4,1,32'h5,  32'h7,  1,0, 0,1,OP_ADD, 2, 3,4,32'h5,  32'h7, 1,0,0));
        vecs.push_back(v(0,0,OP_ADD, 9,10,11,1,32'hAA, 32'hBB, 1,0, 0,1,OP_ADD, 2, 3,4,32'h5,  32'h7, 1,0,0));
        vecs.push_back(v(0,0,OP_LW, 12,13, 0,0,32'hCC, 32'hDD, 1,1, 0,1,OP_ADD, 2, 3,4,32'h5,  32'h7, 1,0,0));
        vecs.push_back(v(0,1,OP_ADD,14,15,16,1,32'hEE, 32'hFF, 1,0, 0,1,OP_ADD, 2, 3,4,32'h5,  32'h7, 1,0,0));
        vecs.push_back(v(1,0,OP_LW,  1, 8, 0,0,32'h100,32'h0,  1,1, 0,1,OP_LW,  1, 8,0,32'h100,32'h0, 1,1,0));
        vecs.push_back(v(1,0,OP_ADD, 8, 3, 5,1,32'h11, 32'h22, 1,0, 1,0,6'h0,   0, 0,0,32'h0,  32'h0, 0,0,1));
        vecs.push_back(v(1,0,OP_ADD, 8, 3, 5,1,32'h11, 32'h22, 1,0, 0,1,OP_ADD, 8, 3,5,32'h11, 32'h22,1,0,1));
        vecs.push_back(v(1,0,OP_LW,  1, 0, 0,0,32'h40, 32'h0,  1,1, 0,1,OP_LW,  1, 0,0,32'h40, 32'h0, 1,1,1));
        vecs.push_back(v(1,0,OP_ADD, 0, 0, 6,1,32'h1,  32'h2,  1,0, 0,1,OP_ADD, 0, 0,6,32'h1,  32'h2, 1,0,1));
        vecs.push_back(v(1,0,OP_LW,  1, 8, 0,0,32'h44, 32'h0,  1,1, 0,1,OP_LW,  1, 8,0,32'h44, 32'h0, 1,1,1));
        vecs.push_back(v(1,0,OP_ADDI,2, 8, 0,0,32'h3,  32'h4,  1,0, 0,1,OP_ADDI,2, 8,0,32'h3,  32'h4, 1,0,1));
        vecs.push_back(v(1,0,OP_LW,  1, 8, 0,0,32'h48, 32'h0,  1,1, 0,1,OP_LW,  1, 8,0,32'h48, 32'h0, 1,1,1));
        vecs.push_back(v(1,1,OP_ADD, 8, 3, 5,1,32'h11, 32'h22, 1,0, 0,0,6'h0,   0, 0,0,32'h0,  32'h0, 0,0,1));
        vecs.push_back(v(1,0,OP_ADD, 8, 8, 5,1,32'h33, 32'h44, 1,0, 0,1,OP_ADD, 8, 8,5,32'h33, 32'h44,1,0,1));
        vecs.push_back(v(1,0,OP_LW,  1, 9, 0,0,32'h4C, 32'h0,  1,1, 0,1,OP_LW,  1, 9,0,32'h4C, 32'h0, 1,1,1));
        vecs.push_back(v(0,0,OP_ADD, 9, 3, 5,1,32'h55, 32'h66, 1,0, 1,1,OP_LW,  1, 9,0,32'h4C, 32'h0, 1,1,1));
        vecs.push_back(v(0,0,OP_ADD, 9, 3, 5,1,32'h55, 32'h66, 1,0, 1,1,OP_LW,  1, 9,0,32'h4C, 32'h0, 1,1,1));
        vecs.push_back(v(1,0,OP_ADD, 9, 3, 5,1,32'h55, 32'h66, 1,0, 1,0,6'h0,   0, 0,0,32'h0,  32'h0, 0,0,2));
        vecs.push_back(v(1,0,OP_ADD, 9, 3, 5,1,32'h55, 32'h66, 1,0, 0,1,OP_ADD, 9, 3,5,32'h55, 32'h66,1,0,2));
        vecs.push_back(v(1,0,OP_LW,  1, 7, 0,0,32'h50, 32'h0,  1,1, 0,1,OP_LW,  1, 7,0,32'h50, 32'h0, 1,1,2));
        vecs.push_back(v(1,0,OP_SW,  3, 7, 0,1,32'h77, 32'h88, 0,0, 1,0,6'h0,   0, 0,0,32'h0,  32'h0, 0,0,3));
        vecs.push_back(v(1,0,OP_SW,  3, 7, 0,1,32'h77, 32'h88, 0,0, 0,1,OP_SW,  3, 7,0,32'h77, 32'h88,0,0,3));

        RST = 1'b1;
        drive(0, 0, OP_ADD, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        step();
        step();
        check_all_zero("reset_init");
        RST = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].fl, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].ur, vecs[i].r1, vecs[i].r2, vecs[i].wen, vecs[i].mr, 0);
            #1;
            check($sformatf("v%0d_stall", i), 32'(ld_use_stall), 32'(vecs[i].x_stall));
            step();
            check($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].x_valid));
            check($sformatf("v%0d_opcode", i), 32'(ex_opcode), 32'(vecs[i].x_op));
            check($sformatf("v%0d_rs", i), 32'(ex_rs), 32'(vecs[i].x_rs));
            check($sformatf("v%0d_rt", i), 32'(ex_rt), 32'(vecs[i].x_rt));
            check($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].x_rd));
            check($sformatf("v%0d_rdat1", i), ex_rdat1, vecs[i].x_r1);
            check($sformatf("v%0d_rdat2", i), ex_rdat2, vecs[i].x_r2);
            check($sformatf("v%0d_wen", i), 32'(ex_WEN), 32'(vecs[i].x_wen));
            check($sformatf("v%0d_mem_ren", i), 32'(ex_mem_ren), 32'(vecs[i].x_mr));
            check($sformatf("v%0d_cnt", i), 32'(bubble_cnt), 32'(vecs[i].x_cnt));
        end
        check("last_npc", ex_npc, 32'h7B);

        // HALT reaches EX, after which nothing may update.
        drive(1, 0, OP_HALT, 0, 0, 0, 0, 32'h90, 32'h0, 0, 0, 1);
        step();
        check("halt_set", 32'(halted), 32'd1);
        check("halt_ex_halt", 32'(ex_halt), 32'd1);
        check("halt_ex_valid", 32'(ex_valid), 32'd1);
        check("halt_ex_opcode", 32'(ex_opcode), 32'(OP_HALT));
        drive(1, 1, OP_LW, 1, 8, 0, 0, 32'h123, 32'h0, 1, 1, 0);
        step();
        drive(1, 0, OP_ADD, 8, 3, 5, 1, 32'h456, 32'h0, 1, 0, 0);
        step();
        check("halt_hold_opcode", 32'(ex_opcode), 32'(OP_HALT));
        check("halt_hold_rdat1", ex_rdat1, 32'h90);
        check("halt_hold_valid", 32'(ex_valid), 32'd1);
        check("halt_hold_halted", 32'(halted), 32'd1);
        check("halt_hold_cnt", 32'(bubble_cnt), 32'd3);

        // Asynchronous reset between edges clears everything at once.
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("reset_async");
        step();
        check_all_zero("reset_held");
        RST = 1'b0;

        // Saturation: start the counter one short of its limit.
        drive(1, 0, OP_LW, 1, 8, 0, 0, 32'h60, 32'h0, 1, 1, 0);
        step();
        check("sat_lw_loaded", 32'(ex_mem_ren), 32'd1);
        force dut.bubble_cnt = 16'hFFFE;
        #1;
        release dut.bubble_cnt;
        drive(1, 0, OP_ADD, 8, 3, 5, 1, 32'h61, 32'h0, 1, 0, 0);
        #1;
        check("sat_stall", 32'(ld_use_stall), 32'd1);
        step();
        check("sat_reach_max", 32'(bubble_cnt), 32'hFFFF);
        drive(1, 0, OP_LW, 1, 8, 0, 0, 32'h62, 32'h0, 1, 1, 0);
        step();
        drive(1, 0, OP_ADD, 8, 3, 5, 1, 32'h63, 32'h0, 1, 0, 0);
        #1;
        check("sat_stall2", 32'(ld_use_stall), 32'd1);
        step();
        check("sat_hold_max", 32'(bubble_cnt), 32'hFFFF);
        check("sat_bubble", 32'(ex_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
